// File: rtl/intra16_recon.sv
// 16x16 luma intra reconstruction: rebuilds the DC/TM/V/H prediction from the
// neighbour edges, adds the dequantised residual one row per cycle and publishes the macroblock.
module intra16_recon #(
  parameter int BLOCK_SIZE = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [9:0]                           x,
  input  logic [9:0]                           y,
  input  logic [31:0]                          mode_i16,
  input  logic [7:0]                           top_left,
  input  logic [8*BLOCK_SIZE-1:0]              top,
  input  logic [8*BLOCK_SIZE-1:0]              left,
  input  logic [16*BLOCK_SIZE*BLOCK_SIZE-1:0]  residual,
  output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]   out,
  output logic                                 busy,
  output logic                                 done
);

  localparam int N  = BLOCK_SIZE;
  localparam int RW = $clog2(N);
  localparam int SW = 8 + RW;  // width of a 16-pixel edge sum

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_PREP = 4'b0010,
    S_ROW  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    MODE_DC = 2'd0,
    MODE_TM = 2'd1,
    MODE_V  = 2'd2,
    MODE_H  = 2'd3
  } mode_t;

  state_t              state;
  logic [RW-1:0]       row;
  logic [9:0]          x_q;
  logic [9:0]          y_q;
  mode_t               mode_q;
  logic [7:0]          top_left_q;
  logic [8*N-1:0]      top_q;
  logic [8*N-1:0]      left_q;
  logic [16*N*N-1:0]   res_q;
  logic [7:0]          dc_q;
  logic [8*N*N-1:0]    buf_q;

  logic                has_top;
  logic                has_left;
  logic [SW-1:0]       sum_top;
  logic [SW-1:0]       sum_left;
  logic [SW:0]         sum_both;
  logic [SW-1:0]       top_rnd;
  logic [SW-1:0]       left_rnd;
  logic [7:0]          dc_val;
  logic [7:0]          left_r;
  logic [8*N-1:0]      row_pix;

  logic                unused_mode_bits;
  assign unused_mode_bits = ^mode_i16[31:2];

  assign has_top  = |y_q;
  assign has_left = |x_q;

  function automatic logic [7:0] clip8(input logic signed [17:0] v);
    if (v < 18'sd0)        return 8'd0;
    else if (v > 18'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  // NOTE: every variable written in always_comb gets a default first so no path infers a latch.
  always_comb begin
    sum_top  = '0;
    sum_left = '0;
    for (int i = 0; i < N; i++) begin
      sum_top  = sum_top  + SW'(top_q[8*i +: 8]);
      sum_left = sum_left + SW'(left_q[8*i +: 8]);
    end
  end

  // Rounded averages: divide by 32 with both edges, by 16 with one edge.
  assign sum_both = {1'b0, sum_top} + {1'b0, sum_left} + (SW+1)'(N);
  assign top_rnd  = sum_top  + SW'(N/2);
  assign left_rnd = sum_left + SW'(N/2);

  always_comb begin
    dc_val = 8'd128;
    unique case ({has_top, has_left})
      2'b11:   dc_val = sum_both[SW:RW+1];
      2'b10:   dc_val = top_rnd[SW-1:RW];
      2'b01:   dc_val = left_rnd[SW-1:RW];
      default: dc_val = 8'd128;
    endcase
  end

  assign left_r = left_q[8*row +: 8];

  logic [7:0]          top_c;
  logic [7:0]          pred;
  logic signed [9:0]   tm;
  logic [15:0]         res_p;
  logic signed [17:0]  recon;

  always_comb begin
    row_pix = '0;
    top_c   = '0;
    pred    = '0;
    tm      = '0;
    res_p   = '0;
    recon   = '0;
    for (int c = 0; c < N; c++) begin
      top_c = top_q[8*c +: 8];
      tm    = $signed({2'b00, left_r}) + $signed({2'b00, top_c})
            - $signed({2'b00, top_left_q});
      unique case (mode_q)
        MODE_DC: pred = dc_q;
        MODE_V:  pred = has_top  ? top_c  : 8'd127;
        MODE_H:  pred = has_left ? left_r : 8'd129;
        MODE_TM: begin
          // A missing edge degrades TM to the directional mode of the edge that remains.
          if (has_top && has_left) pred = clip8({{8{tm[9]}}, tm});
          else if (has_top)        pred = top_c;
          else if (has_left)       pred = left_r;
          else                     pred = 8'd129;
        end
      endcase
      res_p = res_q[16*(N*int'(row) + c) +: 16];
      recon = $signed({10'b0, pred}) + $signed({{2{res_p[15]}}, res_p});
      row_pix[8*c +: 8] = clip8(recon);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  // NOTE: the row buffer is reset along with everything else; an aborted block must leave no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      row        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      mode_q     <= MODE_DC;
      top_left_q <= '0;
      top_q      <= '0;
      left_q     <= '0;
      res_q      <= '0;
      dc_q       <= '0;
      buf_q      <= '0;
      out        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_q        <= x;
            y_q        <= y;
            mode_q     <= mode_t'(mode_i16[1:0]);
            top_left_q <= top_left;
            top_q      <= top;
            left_q     <= left;
            res_q      <= residual;
            busy       <= 1'b1;
            state      <= S_PREP;
          end
        end
        S_PREP: begin
          dc_q  <= dc_val;
          row   <= '0;
          state <= S_ROW;
        end
        S_ROW: begin
          buf_q[8*N*row +: 8*N] <= row_pix;
          row <= row + 1'b1;
          if (row == RW'(N-1)) begin
            // The last row bypasses the buffer so out is complete while done is high.
            out   <= {row_pix, buf_q[8*N*(N-1)-1:0]};
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/intra16_recon.md
Name: intra16_recon

Overview:
- Decoder-side counterpart of the encoder's 16x16 luma intra mode decision.
- Takes the chosen mode_i16 (0=DC, 1=TM, 2=V, 3=H) and the 16x16 residual, which the upstream inverse-transform/dequant stage has already turned into signed pixel differences.
- Regenerates the intra prediction from the neighbour edges, adds the residual row by row with clamping to 0..255, and presents the reconstructed macroblock with a done pulse.
- Sits between the inverse transform and the macroblock edge/line buffers.

Parameters:
- BLOCK_SIZE, 16, block width/height in pixels; only 16 is supported.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- x  input  10  macroblock column; x==0 means there is no left edge.
- y  input  10  macroblock row; y==0 means there is no top edge.
- mode_i16  input  32  prediction mode; only bits [1:0] are used.
- top_left  input  8  corner pixel.
- top  input  8*BLOCK_SIZE  top[c] = bits [8c+:8].
- left  input  8*BLOCK_SIZE  left[r] = bits [8r+:8].
- residual  input  16*BLOCK_SIZE*BLOCK_SIZE  signed two's-complement; pixel (r,c) = bits [16*(16r+c)+:16].
- out  output  8*BLOCK_SIZE*BLOCK_SIZE  reconstructed pixels; (r,c) = bits [8*(16r+c)+:8].
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous): state=IDLE, out=0, busy=0, done=0, row counter=0, all latched inputs=0.
- Capture: on start in IDLE, latch x, y, mode_i16[1:0], top_left, top, left and residual.
  - The upstream buses may change from the next cycle on.
  - start is ignored while not in IDLE; it is neither queued nor does it restart the block.
- State machine (one-hot): IDLE -> PREP -> ROW (16 cycles) -> DONE -> IDLE.
- PREP (1 cycle): compute the DC value from has_top=(y!=0) and has_left=(x!=0); St=sum(top), Sl=sum(left), both 12-bit.
  - has_top && has_left: (St+Sl+16)>>5.
  - has_top only: (St+8)>>4.
  - has_left only: (Sl+8)>>4.
  - neither: 128.
  - Clear the row counter.
- ROW: one row r per cycle, r=0..15 ascending. pred(r,c) per mode:
  - DC: the PREP value.
  - V: top[c] if has_top, else 127.
  - H: left[r] if has_left, else 129.
  - TM:
    - both edges present: clip(left[r]+top[c]-top_left).
    - !has_left && has_top: same as V.
    - has_left && !has_top: same as H.
    - neither edge: 129.
- Arithmetic: recon = clip255(pred + residual(r,c)).
  - Evaluate the sum in at least 18-bit signed.
  - Negative results -> 0; results >255 -> 255.
  - The TM intermediate left+top-top_left is at least 10-bit signed and is clipped to 0..255 before the residual is added.
- Row results go to an internal working buffer. out is updated only in DONE, copying the whole buffer in one cycle, so out stays stable from one done to the next.
- DONE: out <= buffer, done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency: start sampled at cycle T -> done high at cycle T+18.
  - A new start is accepted in the cycle after done (T+19).
  - Throughput: one macroblock per 19 cycles.
- Mode values 0..3 only. mode_i16[31:2] is ignored, so a value of 7 behaves as H.
- Reset asserted mid-operation aborts immediately: all state returns to reset values and out is cleared to 0. No done is produced for the aborted block.
- start held high continuously: a new block is accepted in every IDLE cycle (back-to-back operation, 19-cycle period).

Test Plan:
- Reset: assert rst_n=0 mid-ROW -> out=0, busy=0, done=0 asynchronously. After release there is no done until a new start.
- DC, corner: x=0, y=0, mode=0, residual all 0 -> every out byte 0x80. done exactly 18 cycles after start, busy high for cycles T+1..T+17.
- DC, both edges: x=1, y=1, top all 10, left all 30, residual(r,c)=r-8 -> pred=20, out(r,c)=12+r.
  - Check the no-top case: y=0, left all 30 -> pred=30.
- TM saturation: x=y=1, top_left=200, top all 250, left all 250, residual 0 -> pred clip(300)=255.
  - Residual -300 -> out 0.
  - Residual +32767 -> out 255.
- V/H with edges missing:
  - V with y=0 -> 127.
  - H with x=0 -> 129.
  - TM with x=0, y=3, top[c]=c -> out(r,c)=c.
  - TM with x=0, y=0 -> 129.
- Handshake:
  - start pulsed while busy -> ignored, single done.
  - start held high for 40 cycles -> done at T+18 and T+37.
  - out unchanged between done pulses even though residual changes after capture.
